// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage MIPS core.
// Covers what forwarding cannot: load-use, ID-stage branch operand
// dependences and multi-cycle mult/div occupancy of EX. Also keeps a
// saturating count of cycles in which the PC was held.
module hazard_unit #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_IFID_rs,
  input  logic [4:0]       i_IFID_rt,
  input  logic             i_ID_uses_rt,
  input  logic             i_ID_branch,
  input  logic             i_ID_muldiv,
  input  logic             i_branch_taken,
  input  logic             i_IDEX_MemRead,
  input  logic             i_IDEX_RegWrite,
  input  logic [4:0]       i_IDEX_dest,
  input  logic             i_EXMEM_MemRead,
  input  logic [4:0]       i_EXMEM_dest,
  output logic             o_PC_write,
  output logic             o_IFID_write,
  output logic             o_IDEX_write,
  output logic             o_IDEX_bubble,
  output logic             o_EXMEM_bubble,
  output logic             o_IFID_flush,
  output logic             o_md_busy,
  output logic [CNT_W-1:0] o_stall_count
);

  localparam int            CW      = $clog2(MD_LATENCY + 1);
  localparam logic [CW-1:0] MD_LOAD = CW'(MD_LATENCY - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);
  // A latency of 1 means the mult/div behaves like any single-cycle op.
  localparam bit            MD_HOLD = (MD_LATENCY > 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_stall_count;

  // Register $0 is hard-wired to zero, so a zero destination never matches.
  logic w_ex_nz, w_mem_nz;
  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic w_lu, w_bex, w_bmm, w_dstall, w_md_start;

  assign w_ex_nz  = |i_IDEX_dest;
  assign w_mem_nz = |i_EXMEM_dest;
  assign w_ex_rs  = w_ex_nz  && (i_IDEX_dest  == i_IFID_rs);
  assign w_ex_rt  = w_ex_nz  && (i_IDEX_dest  == i_IFID_rt);
  assign w_mem_rs = w_mem_nz && (i_EXMEM_dest == i_IFID_rs);
  assign w_mem_rt = w_mem_nz && (i_EXMEM_dest == i_IFID_rt);

  // Load-use: the load gates both operand matches; rt only counts if read.
  assign w_lu       = i_IDEX_MemRead && (w_ex_rs || (i_ID_uses_rt && w_ex_rt));
  // Branches compare in ID, so any EX writer or MEM load of an operand stalls.
  assign w_bex      = i_ID_branch && i_IDEX_RegWrite && (w_ex_rs || w_ex_rt);
  assign w_bmm      = i_ID_branch && i_EXMEM_MemRead && (w_mem_rs || w_mem_rt);
  assign w_dstall   = w_lu || w_bex || w_bmm;
  // A mult/div only advances into EX once its operands are clean.
  assign w_md_start = (r_state == S_IDLE) && i_ID_muldiv && !w_dstall && MD_HOLD;

  // Mult/div occupancy FSM: hold EX for MD_LATENCY-1 cycles after issue.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_md_start) begin
            r_state <= S_BUSY;
            r_cnt   <= MD_LOAD;
          end
        end
        S_BUSY: begin
          if (r_cnt == ONE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Pipeline control, prioritised reset > busy > data stall > taken branch.
  always_comb begin
    o_PC_write     = 1'b1;
    o_IFID_write   = 1'b1;
    o_IDEX_write   = 1'b1;
    o_IDEX_bubble  = 1'b0;
    o_EXMEM_bubble = 1'b0;
    o_IFID_flush   = 1'b0;
    o_md_busy      = 1'b0;
    if (i_reset) begin
      o_PC_write     = 1'b0;
      o_IFID_write   = 1'b0;
      o_IDEX_write   = 1'b0;
      o_IDEX_bubble  = 1'b1;
      o_EXMEM_bubble = 1'b1;
      o_IFID_flush   = 1'b1;
    end else if (r_state == S_BUSY) begin
      // Freeze everything up to EX; MEM receives NOPs while the unit works.
      o_PC_write     = 1'b0;
      o_IFID_write   = 1'b0;
      o_IDEX_write   = 1'b0;
      o_EXMEM_bubble = 1'b1;
      o_md_busy      = 1'b1;
    end else if (w_dstall) begin
      // Hold IF/ID and push a NOP into EX; the branch decision waits.
      o_PC_write    = 1'b0;
      o_IFID_write  = 1'b0;
      o_IDEX_bubble = 1'b1;
    end else if (i_branch_taken && i_ID_branch) begin
      o_IFID_flush = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_count <= '0;
    end else if (!o_PC_write && !(&r_stall_count)) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: directed vectors, a behavioural reference
// model compared on every falling edge, and literal spot checks.
module tb_hazard_unit;

  localparam int LAT   = 4;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs, rt, ex_d, mem_d;
  logic       uses_rt, br, md, taken, ex_mr, ex_rw, mem_mr;

  logic          pc_w, ifid_w, idex_w, idex_b, exmem_b, flush, busy;
  logic [CW-1:0] scount;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state: remaining hold cycles and expected stall count.
  int busy_left = 0;
  int m_cnt     = 0;

  hazard_unit #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_IFID_rs(rs), .i_IFID_rt(rt), .i_ID_uses_rt(uses_rt),
    .i_ID_branch(br), .i_ID_muldiv(md), .i_branch_taken(taken),
    .i_IDEX_MemRead(ex_mr), .i_IDEX_RegWrite(ex_rw), .i_IDEX_dest(ex_d),
    .i_EXMEM_MemRead(mem_mr), .i_EXMEM_dest(mem_d),
    .o_PC_write(pc_w), .o_IFID_write(ifid_w), .o_IDEX_write(idex_w),
    .o_IDEX_bubble(idex_b), .o_EXMEM_bubble(exmem_b), .o_IFID_flush(flush),
    .o_md_busy(busy), .o_stall_count(scount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Does a nonzero register d feed an operand the ID instruction reads?
  function automatic bit reads(input logic [4:0] d, input bit rt_read);
    return (d != 5'd0) && ((d == rs) || (rt_read && d == rt));
  endfunction

  function automatic bit m_dstall();
    bit load_use, br_ex, br_mem;
    load_use = ex_mr && reads(ex_d, uses_rt);
    br_ex    = br && ex_rw && reads(ex_d, 1'b1);
    br_mem   = br && mem_mr && reads(mem_d, 1'b1);
    return load_use || br_ex || br_mem;
  endfunction

  // Expected {PC_write, IFID_write, IDEX_write, IDEX_bubble, EXMEM_bubble, flush, busy}
  function automatic logic [6:0] m_out();
    if (reset)           return 7'b000_111_0;
    if (busy_left > 0)   return 7'b000_010_1;
    if (m_dstall())      return 7'b001_100_0;
    if (br && taken)     return 7'b111_001_0;
    return 7'b111_000_0;
  endfunction

  // Model advances on the same edges as the design, including async reset.
  always @(posedge clk or posedge reset) begin
    logic [6:0] v;
    if (reset) begin
      busy_left = 0;
      m_cnt     = 0;
    end else begin
      v = m_out();
      if (!v[6]) m_cnt = (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
      if (busy_left > 0) busy_left = busy_left - 1;
      else if (md && !m_dstall() && LAT > 1) busy_left = LAT - 1;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    logic [6:0] e, a;
    cyc++;
    e = m_out();
    a = {pc_w, ifid_w, idex_w, idex_b, exmem_b, flush, busy};
    $display("cyc %0d rst=%0b out=%b exp=%b cnt=%0d exp_cnt=%0d", cyc, reset, a, e, scount, m_cnt);
    chk("model_outputs", int'(a), int'(e));
    chk("model_count", int'(scount), m_cnt);
  end

  task automatic clr();
    rs = 5'd0; rt = 5'd0; uses_rt = 1'b0; br = 1'b0; md = 1'b0; taken = 1'b0;
    ex_mr = 1'b0; ex_rw = 1'b0; ex_d = 5'd0; mem_mr = 1'b0; mem_d = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    tick(); tick();
    #1;
    chk("rst_flush", int'(flush), 1);
    chk("rst_pcw", int'(pc_w), 0);
    chk("rst_count", int'(scount), 0);
    reset = 1'b0;
    tick();
    #1 chk("release_pcw", int'(pc_w), 1);

    // lw $8 in EX, add rs=$8 in ID
    ex_mr = 1'b1; ex_rw = 1'b1; ex_d = 5'd8; rs = 5'd8; rt = 5'd2; uses_rt = 1'b1;
    #1 chk("lu_pcw", int'(pc_w), 0);
    chk("lu_bubble", int'(idex_b), 1);
    chk("lu_idexw", int'(idex_w), 1);
    tick();
    clr(); mem_mr = 1'b1; mem_d = 5'd8; rs = 5'd8;
    #1 chk("lu_released", int'(pc_w), 1);
    chk("lu_count", int'(scount), 1);
    tick();

    // rt dependence only counts when rt is read
    clr(); ex_mr = 1'b1; ex_d = 5'd5; rs = 5'd1; rt = 5'd5;
    #1 chk("rt_unread", int'(pc_w), 1);
    uses_rt = 1'b1;
    #1 chk("rt_read", int'(pc_w), 0);
    tick();

    // load to $0 never stalls
    clr(); ex_mr = 1'b1; ex_d = 5'd0; uses_rt = 1'b1;
    #1 chk("dest0_pcw", int'(pc_w), 1);
    tick();

    // beq $9: EX writer, then MEM load, then taken
    clr(); br = 1'b1; taken = 1'b1; rs = 5'd9; rt = 5'd3; ex_rw = 1'b1; ex_d = 5'd9;
    #1 chk("bex_pcw", int'(pc_w), 0);
    chk("bex_noflush", int'(flush), 0);
    tick();
    clr(); br = 1'b1; taken = 1'b1; rs = 5'd9; rt = 5'd3; mem_mr = 1'b1; mem_d = 5'd9;
    #1 chk("bmm_pcw", int'(pc_w), 0);
    tick();
    clr(); br = 1'b1; taken = 1'b1; rs = 5'd9; rt = 5'd3;
    #1 chk("taken_flush", int'(flush), 1);
    chk("taken_pcw", int'(pc_w), 1);
    tick();
    clr();
    #1 chk("flush_one_cycle", int'(flush), 0);
    chk("branch_count", int'(scount), 4);

    // mult behind a load-use hazard waits, then occupies EX
    md = 1'b1; ex_mr = 1'b1; ex_d = 5'd4; rs = 5'd4;
    #1 chk("md_hazard_pcw", int'(pc_w), 0);
    tick();
    clr(); md = 1'b1; rs = 5'd4;
    #1 chk("md_issue_busy", int'(busy), 0);
    chk("md_issue_pcw", int'(pc_w), 1);
    tick();
    clr(); br = 1'b1; taken = 1'b1; ex_rw = 1'b1; ex_d = 5'd9; rs = 5'd9;
    #1 chk("busy1", int'(busy), 1);
    chk("busy1_exb", int'(exmem_b), 1);
    chk("busy1_idexw", int'(idex_w), 0);
    chk("busy1_flush", int'(flush), 0);
    chk("busy1_idexb", int'(idex_b), 0);
    tick();
    clr();
    #1 chk("busy2", int'(busy), 1);
    tick();
    #1 chk("busy3", int'(busy), 1);
    tick();
    #1 chk("busy_done", int'(busy), 0);
    chk("busy_done_pcw", int'(pc_w), 1);
    chk("md_count", int'(scount), 8);

    // reset during the second busy cycle
    md = 1'b1;
    tick();
    clr();
    tick();
    #1 chk("pre_rst_busy", int'(busy), 1);
    #1 reset = 1'b1;
    #1 chk("midrst_busy", int'(busy), 0);
    chk("midrst_count", int'(scount), 0);
    chk("midrst_flush", int'(flush), 1);
    chk("midrst_bubbles", int'({idex_b, exmem_b}), 3);
    tick();
    reset = 1'b0;
    tick();
    #1 chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_pcw", int'(pc_w), 1);
    chk("post_rst_count", int'(scount), 0);

    // 20 held cycles saturate a 4-bit counter
    ex_mr = 1'b1; ex_d = 5'd7; rs = 5'd7;
    repeat (20) tick();
    #1 chk("sat_count", int'(scount), 15);
    clr();
    tick();
    #1 chk("sat_hold", int'(scount), 15);

    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
